aes_fifo_sched: RTL and testbench

//  Sequences one AES core between an input block FIFO and an output block FIFO.

---
 rtl/aes_sched_pkg.sv | 14 +
 rtl/aes_fifo_sched.sv | 89 ++++++++
 tb/tb_aes_fifo_sched.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types for the AES FIFO scheduler.
// Holds the scheduler state encoding and the default block width.
package aes_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        WRITE
    } sched_state_t;

    localparam int AES_BLOCK_W = 128;

endpackage

// File: rtl/aes_fifo_sched.sv
// aes_fifo_sched: sequences one AES core between an input and output block FIFO.
// Ports: clk/reset (async, active-high); en gates new blocks;
//   in_fifo_valid/in_fifo_rdata/in_fifo_read_e: show-ahead input FIFO pop side;
//   aes_start/aes_din/aes_done/aes_dout: core start/done handshake;
//   out_fifo_full/out_fifo_write_e/out_fifo_wdata: output FIFO push side;
//   busy: not IDLE; blocks_done: wrapping push count; err: sticky stray aes_done.
module aes_fifo_sched
    import aes_sched_pkg::*;
#(
    parameter int DATA_WIDTH = AES_BLOCK_W,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  in_fifo_valid,
    input  logic [DATA_WIDTH-1:0] in_fifo_rdata,
    output logic                  in_fifo_read_e,
    output logic                  aes_start,
    output logic [DATA_WIDTH-1:0] aes_din,
    input  logic                  aes_done,
    input  logic [DATA_WIDTH-1:0] aes_dout,
    input  logic                  out_fifo_full,
    output logic                  out_fifo_write_e,
    output logic [DATA_WIDTH-1:0] out_fifo_wdata,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  blocks_done,
    output logic                  err
);

    sched_state_t          state;
    logic [DATA_WIDTH-1:0] din_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  launch;
    logic                  push;

    // Pop and push are qualified in the same cycle as the edge that
    // commits them, so the FIFO head moves exactly when din_q captures it
    // and a push can never coincide with full.
    assign launch = (state == IDLE) && en && in_fifo_valid;
    assign push   = (state == WRITE) && !out_fifo_full;

    assign in_fifo_read_e   = launch;
    assign aes_start        = (state == START);
    assign aes_din          = din_q;
    assign out_fifo_write_e = push;
    assign out_fifo_wdata   = dout_q;
    assign busy             = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            din_q       <= '0;
            dout_q      <= '0;
            blocks_done <= '0;
            err         <= 1'b0;
        end else begin
            // A done pulse outside RUN (including the START cycle) is
            // dropped but remembered.
            if (aes_done && (state != RUN)) begin
                err <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        din_q <= in_fifo_rdata;
                        state <= START;
                    end
                end
                START: begin
                    state <= RUN;
                end
                RUN: begin
                    if (aes_done) begin
                        dout_q <= aes_dout;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    if (push) begin
                        blocks_done <= blocks_done + CNT_WIDTH'(1);
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_fifo_sched.sv
// Self-checking bench for aes_fifo_sched with a queue FIFO model,
// a fixed-latency stub AES core and randomized block data.
module tb_aes_fifo_sched;

    localparam int DW  = 128;
    localparam int CW  = 32;
    localparam int LAT = 5;
    localparam logic [DW-1:0] MASK = {16{8'hA5}};

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          in_fifo_valid;
    logic [DW-1:0] in_fifo_rdata;
    logic          in_fifo_read_e;
    logic          aes_start;
    logic [DW-1:0] aes_din;
    logic          aes_done;
    logic [DW-1:0] aes_dout;
    logic          out_fifo_full;
    logic          out_fifo_write_e;
    logic [DW-1:0] out_fifo_wdata;
    logic          busy;
    logic [CW-1:0] blocks_done;
    logic          err;

    aes_fifo_sched #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .en              (en),
        .in_fifo_valid   (in_fifo_valid),
        .in_fifo_rdata   (in_fifo_rdata),
        .in_fifo_read_e  (in_fifo_read_e),
        .aes_start       (aes_start),
        .aes_din         (aes_din),
        .aes_done        (aes_done),
        .aes_dout        (aes_dout),
        .out_fifo_full   (out_fifo_full),
        .out_fifo_write_e(out_fifo_write_e),
        .out_fifo_wdata  (out_fifo_wdata),
        .busy            (busy),
        .blocks_done     (blocks_done),
        .err             (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Environment state, owned by the driver process below.
    logic [DW-1:0] in_q[$];
    logic [DW-1:0] feed_q[$];
    logic [DW-1:0] got_q[$];
    int            got_cyc[$];
    logic [DW-1:0] start_din_q[$];
    logic          flush_req = 1'b0;
    logic          spur_req  = 1'b0;
    logic [DW-1:0] stub_data = '0;
    int cyc       = 0;
    int n_pop     = 0;
    int n_start   = 0;
    int n_push    = 0;
    int n_fire    = 0;
    int n_viol    = 0;
    int pop_cyc   = -1;
    int start_cyc = -1;
    int push_cyc  = -1;
    int fire_cyc  = -1;
    int done_at   = -1;

    // Observe at negedge, apply FIFO/core reactions just after posedge.
    always begin
        logic pop_now;
        logic start_now;
        @(negedge clk);
        pop_now   = in_fifo_read_e;
        start_now = aes_start;
        if (pop_now) begin
            n_pop++;
            pop_cyc = cyc;
        end
        if (start_now) begin
            n_start++;
            start_cyc = cyc;
            start_din_q.push_back(aes_din);
            stub_data = aes_din ^ MASK;
        end
        if (out_fifo_write_e) begin
            n_push++;
            push_cyc = cyc;
            got_q.push_back(out_fifo_wdata);
            got_cyc.push_back(cyc);
            if (out_fifo_full) n_viol++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pop_now && in_q.size() != 0) void'(in_q.pop_front());
        if (flush_req) begin
            in_q.delete();
            flush_req = 1'b0;
        end
        while (feed_q.size() != 0) in_q.push_back(feed_q.pop_front());
        in_fifo_valid = (in_q.size() != 0);
        in_fifo_rdata = in_fifo_valid ? in_q[0] : '0;
        if (start_now) done_at = start_cyc + LAT;
        aes_done = 1'b0;
        aes_dout = '0;
        if (cyc == done_at) begin
            aes_done = 1'b1;
            aes_dout = stub_data;
            n_fire++;
            fire_cyc = cyc;
        end else if (spur_req) begin
            aes_done = 1'b1;
            aes_dout = {$urandom, $urandom, $urandom, $urandom};
        end
        spur_req = 1'b0;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [DW-1:0] rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_fifo_read_e, aes_start, out_fifo_write_e, busy, err} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctl got=%b want=00000",
                     {in_fifo_read_e, aes_start, out_fifo_write_e, busy, err});
        end
        n_cmp++;
        if (blocks_done !== '0 || aes_din !== '0 || out_fifo_wdata !== '0) begin
            n_bad++;
            $display("FAIL reset_data cnt=%0d din=%h wdata=%h want 0",
                     blocks_done, aes_din, out_fifo_wdata);
        end
        feed_q.push_back(rnd_blk());
        tick(12);
        n_cmp++;
        if (n_pop !== 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL en_low_hold pops=%0d busy=%b want 0/0", n_pop, busy);
        end
        flush_req = 1'b1;
        tick(2);
    endtask

    task automatic test_single();
        logic [DW-1:0] w;
        int base;
        int bi;
        w    = 128'h00112233445566778899AABBCCDDEEFF;
        base = n_push;
        bi   = got_q.size();
        en   = 1'b1;
        feed_q.push_back(w);
        for (int k = 0; k < 40 && n_push == base; k++) tick(1);
        n_cmp++;
        if (n_push != base + 1) begin
            n_bad++;
            $display("FAIL single_push pushes=%0d want %0d", n_push, base + 1);
        end else begin
            n_cmp++;
            if (got_q[bi] !== (w ^ MASK)) begin
                n_bad++;
                $display("FAIL single_data got=%h want=%h", got_q[bi], w ^ MASK);
            end
            n_cmp++;
            if (start_cyc - pop_cyc != 1) begin
                n_bad++;
                $display("FAIL pop_to_start got=%0d want=1", start_cyc - pop_cyc);
            end
            n_cmp++;
            if (push_cyc - pop_cyc != LAT + 2) begin
                n_bad++;
                $display("FAIL pop_to_push got=%0d want=%0d",
                         push_cyc - pop_cyc, LAT + 2);
            end
            n_cmp++;
            if (start_din_q[start_din_q.size() - 1] !== w) begin
                n_bad++;
                $display("FAIL single_din got=%h want=%h",
                         start_din_q[start_din_q.size() - 1], w);
            end
        end
        n_cmp++;
        if (blocks_done !== CW'(1)) begin
            n_bad++;
            $display("FAIL single_count got=%0d want=1", blocks_done);
        end
        en = 1'b0;
        tick(2);
    endtask

    task automatic test_stream();
        logic [DW-1:0] exp_q[$];
        int bp;
        int bs;
        int bw;
        int bi;
        int bad;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        bp = n_pop;
        bs = n_start;
        bw = n_push;
        bi = got_q.size();
        for (int i = 0; i < 50; i++) begin
            logic [DW-1:0] w;
            w = rnd_blk();
            feed_q.push_back(w);
            exp_q.push_back(w ^ MASK);
        end
        en = 1'b1;
        for (int k = 0; k < 50 * (LAT + 3) + 40 && n_push < bw + 50; k++) tick(1);
        en = 1'b0;
        tick(2);
        n_cmp++;
        if (n_pop - bp != 50 || n_start - bs != 50 || n_push - bw != 50) begin
            n_bad++;
            $display("FAIL stream_counts pop=%0d start=%0d push=%0d want 50",
                     n_pop - bp, n_start - bs, n_push - bw);
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (bi + i >= got_q.size() || got_q[bi + i] !== exp_q[i]) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL stream_data wrong_blocks=%0d want 0", bad);
        end
        n_cmp++;
        if (blocks_done !== CW'(50)) begin
            n_bad++;
            $display("FAIL stream_count got=%0d want=50", blocks_done);
        end
        if (got_q.size() >= bi + 50) begin
            n_cmp++;
            if (got_cyc[bi + 49] - got_cyc[bi] != 49 * (LAT + 3)) begin
                n_bad++;
                $display("FAIL stream_period got=%0d want=%0d",
                         got_cyc[bi + 49] - got_cyc[bi], 49 * (LAT + 3));
            end
        end
    endtask

    task automatic test_full();
        logic [DW-1:0] w;
        int bw;
        int bf;
        int bi;
        int d;
        w  = rnd_blk();
        bw = n_push;
        bf = n_fire;
        bi = got_q.size();
        out_fifo_full = 1'b1;
        en = 1'b1;
        feed_q.push_back(w);
        for (int k = 0; k < 40 && n_fire == bf; k++) tick(1);
        d = fire_cyc;
        tick(8);
        n_cmp++;
        if (n_push != bw) begin
            n_bad++;
            $display("FAIL full_hold pushes=%0d want %0d", n_push, bw);
        end
        out_fifo_full = 1'b0;
        tick(2);
        n_cmp++;
        if (n_push != bw + 1 || push_cyc != d + 8) begin
            n_bad++;
            $display("FAIL full_release pushes=%0d at=%0d want %0d at %0d",
                     n_push, push_cyc, bw + 1, d + 8);
        end else begin
            n_cmp++;
            if (got_q[bi] !== (w ^ MASK)) begin
                n_bad++;
                $display("FAIL full_data got=%h want=%h", got_q[bi], w ^ MASK);
            end
        end
        en = 1'b0;
        tick(2);
    endtask

    task automatic test_spurious();
        logic [DW-1:0] w0;
        int bp;
        int bs;
        int bw;
        int bi;
        bw = n_push;
        spur_req = 1'b1;
        tick(3);
        n_cmp++;
        if (err !== 1'b1 || busy !== 1'b0 || n_push != bw) begin
            n_bad++;
            $display("FAIL spurious err=%b busy=%b pushes=%0d want 1/0/%0d",
                     err, busy, n_push, bw);
        end
        w0 = rnd_blk();
        bp = n_pop;
        bs = n_start;
        bi = got_q.size();
        feed_q.push_back(w0);
        feed_q.push_back(rnd_blk());
        en = 1'b1;
        for (int k = 0; k < 20 && n_start == bs; k++) tick(1);
        tick(2);
        en = 1'b0;
        for (int k = 0; k < 30 && n_push == bw; k++) tick(1);
        tick(15);
        n_cmp++;
        if (n_pop - bp != 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL en_drop pops=%0d busy=%b want 1/0", n_pop - bp, busy);
        end
        n_cmp++;
        if (got_q.size() != bi + 1 || got_q[bi] !== (w0 ^ MASK)) begin
            n_bad++;
            $display("FAIL en_drop_data n=%0d want=%h", got_q.size() - bi, w0 ^ MASK);
        end
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky got=%b want=1", err);
        end
        flush_req = 1'b1;
        tick(2);
    endtask

    task automatic test_reset_mid();
        int bp;
        int bs;
        int bw;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        bp = n_pop;
        bs = n_start;
        bw = n_push;
        feed_q.push_back(rnd_blk());
        en = 1'b1;
        for (int k = 0; k < 20 && n_start == bs; k++) tick(1);
        tick(2);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || blocks_done !== '0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid busy=%b cnt=%0d err=%b want 0/0/0",
                     busy, blocks_done, err);
        end
        en = 1'b0;
        tick(6);
        reset = 1'b0;
        tick(6);
        n_cmp++;
        if (err !== 1'b0 || busy !== 1'b0 || n_push != bw || n_pop - bp != 1) begin
            n_bad++;
            $display("FAIL reset_late_done err=%b busy=%b push=%0d pop=%0d",
                     err, busy, n_push - bw, n_pop - bp);
        end
        n_cmp++;
        if (n_viol != 0) begin
            n_bad++;
            $display("FAIL write_while_full got=%0d want=0", n_viol);
        end
    endtask

    initial begin
        reset         = 1'b1;
        en            = 1'b0;
        in_fifo_valid = 1'b0;
        in_fifo_rdata = '0;
        aes_done      = 1'b0;
        aes_dout      = '0;
        out_fifo_full = 1'b0;
        test_reset();
        test_single();
        test_stream();
        test_full();
        test_spurious();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
